// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed 4-digit seven-segment display. It rebuilds the
// four digit codes from the anode strobes and cathodes, accepting a pattern only after it holds stable.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  AN,
  input  logic [6:0]  C,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        an_err,
  output logic [3:0]  cap_mask
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES);

  logic [3:0]       an_s_q, an_p_q;
  logic [6:0]       c_s_q, c_p_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      digits_q, digits_d;
  logic [3:0]       mask_q, mask_d;
  logic             fv_q, fv_d;
  logic             seg_err_q, seg_err_d;
  logic             an_err_q, an_err_d;

  logic       same, capture, one_hot;
  logic [3:0] an_n;
  logic [4:0] dec;

  // Returns {illegal, code}; an all-dark pattern is a legal blank.
  function automatic logic [4:0] decode(input logic [6:0] c);
    case (c)
      7'b0000001: decode = 5'h00;
      7'b1001111: decode = 5'h01;
      7'b0010010: decode = 5'h02;
      7'b0000110: decode = 5'h03;
      7'b1001100: decode = 5'h04;
      7'b0100100: decode = 5'h05;
      7'b0100000: decode = 5'h06;
      7'b0001111: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0000100: decode = 5'h09;
      7'b1111111: decode = 5'h0F;
      default:    decode = 5'h1E;
    endcase
  endfunction

  always_comb begin
    same    = ({an_s_q, c_s_q} == {an_p_q, c_p_q});
    an_n    = ~an_s_q;
    one_hot = (an_n != 4'b0000) && ((an_n & (an_n - 4'd1)) == 4'b0000);
    dec     = decode(c_s_q);
    // Fires only on the transition into saturation, so a held pattern captures once.
    capture = same && (cnt_q == CntMax - 1'b1);

    if (!same)               cnt_d = '0;
    else if (cnt_q < CntMax) cnt_d = cnt_q + 1'b1;
    else                     cnt_d = cnt_q;

    shadow_d  = shadow_q;
    seg_err_d = seg_err_q;
    an_err_d  = an_err_q;
    fv_d      = (mask_q == 4'hF);
    digits_d  = fv_d ? shadow_q : digits_q;
    mask_d    = fv_d ? 4'h0 : mask_q;

    if (capture) begin
      if (one_hot) begin
        for (int i = 0; i < 4; i++) begin
          if (an_n[i]) begin
            shadow_d[4*i +: 4] = dec[3:0];
            mask_d[i]          = 1'b1;
          end
        end
        if (dec[4]) seg_err_d = 1'b1;
      end else if (an_n != 4'b0000) begin
        an_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      an_s_q    <= 4'hF;
      c_s_q     <= 7'h7F;
      an_p_q    <= 4'hF;
      c_p_q     <= 7'h7F;
      cnt_q     <= '0;
      shadow_q  <= 16'hFFFF;
      digits_q  <= 16'hFFFF;
      mask_q    <= 4'h0;
      fv_q      <= 1'b0;
      seg_err_q <= 1'b0;
      an_err_q  <= 1'b0;
    end else begin
      an_s_q    <= AN;
      c_s_q     <= C;
      an_p_q    <= an_s_q;
      c_p_q     <= c_s_q;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      digits_q  <= digits_d;
      mask_q    <= mask_d;
      fv_q      <= fv_d;
      seg_err_q <= seg_err_d;
      an_err_q  <= an_err_d;
    end
  end

  assign digits      = digits_q;
  assign frame_valid = fv_q;
  assign seg_err     = seg_err_q;
  assign an_err      = an_err_q;
  assign cap_mask    = mask_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scans plus random holds, checked every cycle
// against a run-length model of the display-sampling rules.
module tb_seg7_scan_decoder;

  localparam int S = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  AN;
  logic [6:0]  C;
  logic [15:0] digits;
  logic        frame_valid, seg_err, an_err;
  logic [3:0]  cap_mask;

  seg7_scan_decoder #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .AN          (AN),
    .C           (C),
    .digits      (digits),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .an_err      (an_err),
    .cap_mask    (cap_mask)
  );

  always #5 clock = ~clock;

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  // Model state: run length of identical input samples, plus frame bookkeeping.
  logic [3:0]  m_an_last;
  logic [6:0]  m_c_last;
  int          m_run;
  logic [3:0]  m_shadow [4];
  logic [3:0]  m_mask;
  logic [15:0] m_digits;
  logic        m_fv, m_seg, m_an;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int fv_times[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic       cap;
    logic [3:0] lows;
    int         code;
    bit         bad;
    if (reset) begin
      m_an_last = 4'hF; m_c_last = 7'h7F; m_run = 1;
      for (int i = 0; i < 4; i++) m_shadow[i] = 4'hF;
      m_mask = 4'h0; m_digits = 16'hFFFF; m_fv = 0; m_seg = 0; m_an = 0;
    end else begin
      // A sample is acted on once it has been seen S+1 times in a row (S unchanged cycles).
      cap  = (m_run == S + 1);
      m_fv = (m_mask == 4'hF);
      if (m_fv) begin
        m_digits = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
        m_mask   = 4'h0;
      end
      if (cap) begin
        lows = ~m_an_last;
        if ($countones(lows) == 1) begin
          code = 14; bad = 1;
          if (m_c_last == 7'h7F) begin code = 15; bad = 0; end
          for (int k = 0; k < 10; k++) if (seg_tab[k] == m_c_last) begin code = k; bad = 0; end
          for (int i = 0; i < 4; i++) if (lows[i]) begin
            m_shadow[i] = 4'(code);
            m_mask[i]   = 1'b1;
          end
          if (bad) m_seg = 1;
        end else if ($countones(lows) > 1) begin
          m_an = 1;
        end
      end
      if (AN == m_an_last && C == m_c_last) m_run++;
      else m_run = 1;
      m_an_last = AN; m_c_last = C;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    cycle++;
    @(negedge clock);
    check("digits", digits, m_digits);
    check("frame_valid", 16'(frame_valid), 16'(m_fv));
    check("seg_err", 16'(seg_err), 16'(m_seg));
    check("an_err", 16'(an_err), 16'(m_an));
    check("cap_mask", 16'(cap_mask), 16'(m_mask));
    if (frame_valid) fv_times.push_back(cycle);
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] c, input int n);
    AN = an; C = c;
    repeat (n) step();
  endtask

  task automatic scan(input int d0, input int d1, input int d2, input int d3);
    hold(4'b1110, seg_tab[d0], 8);
    hold(4'b1101, seg_tab[d1], 8);
    hold(4'b1011, seg_tab[d2], 8);
    hold(4'b0111, seg_tab[d3], 8);
  endtask

  initial begin
    reset = 1'b1; AN = 4'hF; C = 7'h7F;
    repeat (3) step();
    check("reset_digits", digits, 16'hFFFF);
    check("reset_mask", 16'(cap_mask), 16'h0);
    reset = 1'b0;
    hold(4'hF, 7'h7F, 3);

    // Basic frame
    scan(4, 3, 2, 1);
    hold(4'hF, 7'h7F, 2);
    check("t1_digits", digits, 16'h1234);
    check("t1_errs", 16'({seg_err, an_err}), 16'h0);

    // Three back-to-back frames, 32 cycles apart
    fv_times.delete();
    repeat (3) scan(5, 9, 0, 0);
    check("t2_digits", digits, 16'h0095);
    check("t2_pulses", 16'(fv_times.size()), 16'd3);
    if (fv_times.size() == 3) begin
      check("t2_gap0", 16'(fv_times[1] - fv_times[0]), 16'd32);
      check("t2_gap1", 16'(fv_times[2] - fv_times[1]), 16'd32);
    end

    // Glitch shorter than the window on digit 2
    hold(4'b1110, seg_tab[7], 8);
    hold(4'b1101, seg_tab[6], 8);
    hold(4'b1011, seg_tab[8], 3);
    hold(4'b1011, seg_tab[3], 4);
    check("t3_no_early", 16'(cap_mask[2]), 16'h0);
    hold(4'b1011, seg_tab[3], 4);
    hold(4'b0111, seg_tab[2], 8);
    check("t3_digits", digits, 16'h2367);

    // Two anodes low
    hold(4'b1100, seg_tab[1], 10);
    check("t4_an_err", 16'(an_err), 16'h1);
    check("t4_mask", 16'(cap_mask), 16'h0);
    scan(1, 2, 3, 4);
    check("t4_digits", digits, 16'h4321);
    check("t4_sticky", 16'(an_err), 16'h1);

    // Illegal and blank patterns
    hold(4'b1110, seg_tab[0], 8);
    hold(4'b1101, 7'b1111110, 8);
    hold(4'b1011, seg_tab[8], 8);
    hold(4'b0111, 7'b1111111, 8);
    check("t5_digits", digits, 16'hF8E0);
    check("t5_seg_err", 16'(seg_err), 16'h1);

    // Reset mid-frame
    hold(4'b1110, seg_tab[1], 8);
    hold(4'b1101, seg_tab[1], 8);
    hold(4'b1011, seg_tab[1], 8);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_mask", 16'(cap_mask), 16'h0);
    check("t6_digits", digits, 16'hFFFF);
    check("t6_errs", 16'({seg_err, an_err}), 16'h0);
    fv_times.delete();
    hold(4'b0111, seg_tab[9], 8);
    check("t6_no_frame", 16'(fv_times.size()), 16'd0);
    scan(6, 7, 8, 9);
    check("t6_digits2", digits, 16'h9876);

    // Random holds of mixed patterns
    for (int n = 0; n < 400; n++) begin
      logic [3:0] an;
      logic [6:0] c;
      int r;
      r  = $urandom_range(0, 99);
      an = 4'hF;
      if (r < 75)      an[$urandom_range(0, 3)] = 1'b0;
      else if (r < 85) an = 4'(($urandom_range(0, 2) == 0) ? 4'b0011 : 4'b1010);
      r = $urandom_range(0, 99);
      if (r < 85)      c = seg_tab[$urandom_range(0, 9)];
      else if (r < 92) c = 7'h7F;
      else             c = 7'($urandom);
      if ($urandom_range(0, 99) < 2) begin
        reset = 1'b1; step(); reset = 1'b0;
      end
      hold(an, c, $urandom_range(1, 10));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive end of the multiplexed 4-digit seven-segment interface driven by digital_clock: takes the active-low anode strobes AN and active-low cathodes C and reconstructs the four displayed digit codes.
- Each digit is accepted only after its AN/C pattern holds stable for a programmable number of cycles. A frame is published atomically once all four digits have been captured.
- Intended as an on-chip display monitor and as a self-checking sink for display-driver benches.

Parameters:
- STABLE_CYCLES, 4, consecutive cycles AN and C must be unchanged before a digit is captured (legal range 1..255).
- CNT_W, 8, width of the stability counter; must hold STABLE_CYCLES.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- AN  input  4  anode strobes, active-low; AN[i]=0 selects digit i (digit 0 = rightmost).
- C  input  7  cathodes, active-low, C[6..0] = segments a,b,c,d,e,f,g.
- digits  output  16  last complete frame, digit i in digits[4i+3:4i].
- frame_valid  output  1  one-cycle pulse when digits is updated.
- seg_err  output  1  sticky: an unrecognised segment pattern was captured.
- an_err  output  1  sticky: a stable AN had more than one bit low.
- cap_mask  output  4  digits captured in the current, incomplete frame (debug).

Behaviour:
- Reset values, applied on the first rising edge with reset=1:
  - digits=16'hFFFF, frame_valid=0, seg_err=0, an_err=0, cap_mask=4'b0000.
  - Stability counter=0, previous-sample registers = AN 4'b1111, C 7'b1111111.
  - reset has priority over every other event, including a capture or publish in the same cycle.
- Input registration:
  - AN and C are registered once (sample stage) before use.
  - All decisions use the registered values; input-to-capture latency is 1 cycle plus the stability window.
- Stability counter:
  - If the sampled {AN,C} differs from the previous sample, the counter is cleared to 0.
  - Otherwise it increments, saturating at STABLE_CYCLES.
  - A capture event fires exactly once, on the cycle the counter reaches STABLE_CYCLES. No re-capture happens until {AN,C} changes.
- Capture event:
  - Exactly one AN bit low (digit i): decode C into shadow[i] and set cap_mask[i]. A second capture of the same digit within a frame overwrites shadow[i].
  - AN=4'b1111: ignored, no state change.
  - Two or more AN bits low: set an_err; shadow and cap_mask are unchanged.
- Decode table (C active-low, abcdefg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - 1111111 -> 4'hF (blank, legal).
  - Any other pattern -> 4'hE and seg_err set.
- Frame publish:
  - On the cycle after cap_mask becomes 4'b1111: digits<=shadow, frame_valid=1 for exactly one cycle, cap_mask<=0.
  - A capture in the publish cycle counts toward the next frame.
- Sticky errors: seg_err and an_err clear only on reset.
- Reset mid-frame: the partial frame is discarded; digits returns to 16'hFFFF.
- Glitch rejection: a pattern held fewer than STABLE_CYCLES cycles is never captured. Anode-change transients with stale C are rejected by the same rule.

Test Plan:
1. Reset, then scan AN=1110/1101/1011/0111 with C encoding 4,3,2,1, each held 8 cycles, STABLE_CYCLES=4 -> after the fourth digit, one frame_valid pulse and digits=16'h1234; seg_err=0, an_err=0.
2. Continuous scan repeated 3 frames with values changing to 5,9,0,0 -> three frame_valid pulses; final digits=16'h0095; pulses exactly 32 cycles apart.
3. Digit 2 presented for only 3 cycles, then correctly for 8 -> glitch not captured, cap_mask[2] set only on the 4th stable cycle of the long hold; frame published normally.
4. AN=1100 held 10 cycles -> an_err=1 and stays 1, cap_mask unchanged; subsequent legal frame still publishes.
5. C=1111110 (segment g only lit... illegal) on digit 1 -> seg_err=1; published digit 1 = 4'hE; blank C=1111111 on digit 3 -> 4'hF with no error.
6. Assert reset after 3 digits captured -> cap_mask=0, digits=16'hFFFF, errors cleared; a full 4-digit scan is then needed for the next frame_valid.
